// File: rtl/memory_control_if.sv
// memory_control_if: cache-side request/response bundle between the per-CPU caches and memory_control
// Signals: iREN/dREN/dWEN request bits, iaddr/daddr/dstore per-core address and data slices,
//          iwait/dwait hold-off bits, iload/dload per-core returned words.
interface memory_control_if #(
  parameter int NCPU = 2
);
  logic [NCPU-1:0]    iREN, dREN, dWEN, iwait, dwait;
  logic [NCPU*32-1:0] iaddr, daddr, dstore, iload, dload;
  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore,
    output iwait, dwait, iload, dload
  );
  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore,
    input  iwait, dwait, iload, dload
  );
endinterface

// File: rtl/memory_control.sv
// memory_control: round-robin arbiter running one cache request at a time against the shared RAM
// Ports: CLK rising-edge clock; nRST async active-low reset; ccif cache requests, wait bits and load data;
//        ramREN/ramWEN/ramaddr/ramstore RAM command; ramload/ramstate RAM response; memerr sticky error flag.
module memory_control #(
  parameter int NCPU    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            nRST,
  memory_control_if.slave ccif,
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  logic [1:0]      ramstate,
  output logic            memerr
);
  localparam int NS = 2 * NCPU;
  localparam int IW = $clog2(NS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state, nxt;
  logic [IW-1:0] ptr, gnt, pick, j;
  logic [NS-1:0] act;
  logic [31:0]   s_addr [NS];
  logic [31:0]   s_dat [NS];
  logic [NS-1:0] s_wr;
  logic [31:0]   ld [NS];
  logic [31:0]   addr, wdat;
  logic [7:0]    cnt;
  logic          wr, found, gone, hit, fail;
  // even sources are the data port of a core, odd sources its instruction port
  always_comb begin
    act = '0;
    s_wr = '0;
    for (int c = 0; c < NCPU; c++) begin
      act[2*c]      = ccif.dREN[c] | ccif.dWEN[c];
      act[2*c+1]    = ccif.iREN[c];
      s_wr[2*c]     = ccif.dWEN[c];
      s_addr[2*c]   = ccif.daddr[32*c +: 32];
      s_addr[2*c+1] = ccif.iaddr[32*c +: 32];
      s_dat[2*c]    = ccif.dstore[32*c +: 32];
      s_dat[2*c+1]  = '0;
    end
  end
  // scan from the far end back toward ptr so the nearest active source is the last one written
  always_comb begin
    pick = '0;
    found = 1'b0;
    j = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NS);
      if (act[j]) begin
        pick = j;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    gone = !act[gnt];
    hit  = ramstate == 2'd2;
    fail = ramstate == 2'd3 || cnt == 8'(TIMEOUT - 1);
    nxt  = state == IDLE ? (found ? BUSY : IDLE) :
           state == BUSY ? (gone ? IDLE : (hit || fail) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      ptr <= '0;
      gnt <= '0;
      addr <= '0;
      wdat <= '0;
      wr <= 1'b0;
      cnt <= '0;
      memerr <= 1'b0;
      for (int s = 0; s < NS; s++) ld[s] <= '0;
    end else begin
      if (state == IDLE && found) begin
        gnt <= pick;
        addr <= s_addr[pick];
        wdat <= s_dat[pick];
        wr <= s_wr[pick];
        cnt <= '0;
      end
      // the load slice is written on entry to DONE so it is already valid while the wait bit is low
      if (state == BUSY && !gone) begin
        if (!hit && fail) memerr <= 1'b1;
        if ((hit || fail) && !wr) ld[gnt] <= hit ? ramload : 32'hBAD1BAD1;
        if (!hit && !fail) cnt <= cnt + 8'd1;
      end
      if (state == DONE) ptr <= int'(gnt) == NS - 1 ? '0 : gnt + 1'b1;
    end
  assign ramREN   = state == BUSY && !wr;
  assign ramWEN   = state == BUSY && wr;
  assign ramaddr  = addr;
  assign ramstore = wdat;
  for (genvar c = 0; c < NCPU; c++) begin : g_core
    assign ccif.dwait[c] = !(state == DONE && gnt == IW'(2 * c));
    assign ccif.iwait[c] = !(state == DONE && gnt == IW'(2 * c + 1));
    assign ccif.dload[32*c +: 32] = ld[2*c];
    assign ccif.iload[32*c +: 32] = ld[2*c+1];
  end
endmodule
